// File: rtl/ledr_pattern_sequencer.sv
// Avalon-MM LED pattern sequencer: replays up to 4 CPU-loaded patterns onto the LEDR PIO write port.
// Define LEDR_SEQ_IRQ_EN to build the level-sensitive sequence-done interrupt.
module ledr_pattern_sequencer #(
  parameter int LED_W      = 10,
  parameter int PERIOD_W   = 26,
  parameter int PERIOD_RST = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t              state;
  logic                run, loop, done, dpend;
  logic [1:0]          len, idx;
  logic [PERIOD_W-1:0] period, cnt;
  logic [LED_W-1:0]    pat [4];
  logic [LED_W-1:0]    dval;

  logic                wr, ctrl_wr, direct_wr, status_wr;
  logic                busy, more, expired, direct_go;
  logic [1:0]          next_idx;
  logic [PERIOD_W-1:0] reload;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == 3'd0);
  assign direct_wr = wr && (address == 3'd2);
  assign status_wr = wr && (address == 3'd3);
  assign busy      = (state == S_LOAD) || (state == S_WAIT);
  assign more      = idx < len;
  assign next_idx  = more ? idx + 2'd1 : 2'd0;
  assign expired   = (state == S_WAIT) && (cnt == '0);
  assign reload    = (period == '0) ? '0 : period - PERIOD_W'(1);
  // A pending direct value is held back while a newer direct write overwrites it.
  assign direct_go = dpend && !direct_wr;
  assign pio_address = 2'd0;

  always_comb begin
    // NOTE: default first so no path through the case leaves readdata unassigned (no latch).
    readdata = '0;
    case (address)
      3'd0:    readdata[3:0] = {len, loop, run};
      3'd1:    readdata[PERIOD_W-1:0] = period;
      3'd3:    readdata[4:0] = {dpend, done, idx, busy};
      default: if (address[2]) readdata[LED_W-1:0] = pat[address[1:0]];
    endcase
  end

  // NOTE: all state uses non-blocking assignments; the pattern array is small enough to reset as registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      run            <= 1'b0;
      loop           <= 1'b0;
      len            <= '0;
      idx            <= '0;
      done           <= 1'b0;
      dpend          <= 1'b0;
      dval           <= '0;
      period         <= PERIOD_W'(PERIOD_RST);
      cnt            <= '0;
      for (int i = 0; i < 4; i++) pat[i] <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
`ifdef LEDR_SEQ_IRQ_EN
      irq            <= 1'b0;
`endif
    end else begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;

      if (ctrl_wr) {len, loop, run} <= writedata[3:0];
      if (wr && address == 3'd1) period <= writedata[PERIOD_W-1:0];
      if (wr && address[2]) pat[address[1:0]] <= writedata[LED_W-1:0];
      if (status_wr && writedata[3]) begin
        done <= 1'b0;
`ifdef LEDR_SEQ_IRQ_EN
        irq  <= 1'b0;
`endif
      end

      if (direct_wr) begin
        dpend <= 1'b1;
        dval  <= writedata[LED_W-1:0];
      end else if (direct_go) begin
        dpend          <= 1'b0;
        pio_chipselect <= 1'b1;
        pio_write_n    <= 1'b0;
        pio_writedata  <= {{(32-LED_W){1'b0}}, dval};
      end

      if (ctrl_wr && writedata[0]) begin
        state <= S_LOAD;
        idx   <= '0;
        done  <= 1'b0;
      end else if (ctrl_wr && busy) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: ;
          S_LOAD: begin
            if (!direct_go) begin
              pio_chipselect <= 1'b1;
              pio_write_n    <= 1'b0;
              pio_writedata  <= {{(32-LED_W){1'b0}}, pat[idx]};
              cnt            <= reload;
              state          <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (!expired) begin
              cnt <= cnt - PERIOD_W'(1);
            end else if (more || loop) begin
              // Expiry doubles as the next LOAD so strobes land exactly PERIOD cycles apart.
              idx <= next_idx;
              if (direct_go) begin
                state <= S_LOAD;
              end else begin
                pio_chipselect <= 1'b1;
                pio_write_n    <= 1'b0;
                pio_writedata  <= {{(32-LED_W){1'b0}}, pat[next_idx]};
                cnt            <= reload;
              end
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              run   <= 1'b0;
`ifdef LEDR_SEQ_IRQ_EN
              irq   <= 1'b1;
`endif
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifndef LEDR_SEQ_IRQ_EN
  assign irq = 1'b0;
`endif

endmodule
